// File: rtl/gpio_handshake_responder_pkg.sv
// Shared definitions for the GPIO checkbit handshake responder:
// FSM encoding and the fixed step table the firmware walks through.
package gpio_handshake_pkg;

  localparam int N_STEPS = 6;
  localparam logic [2:0] LAST_STEP = 3'(N_STEPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MATCH,
    ST_DELAY,
    ST_DRIVE,
    ST_PASS,
    ST_FAIL
  } state_e;

  // The final step has no response; a match there is the terminal pass.
  localparam logic [7:0] EXP_HI [0:N_STEPS-1] = '{8'hA0, 8'h0B, 8'hAB, 8'h01, 8'h02, 8'h04};
  localparam logic [7:0] RSP_LO [0:N_STEPS-2] = '{8'hF0, 8'h0F, 8'h00, 8'h01, 8'h03};
  localparam logic       DLY_EN [0:N_STEPS-2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/gpio_handshake_responder_if.sv
// Pad-side handshake bundle: the harness drives enable and the upper
// checkbit byte, the responder answers on the lower byte plus status.
interface gpio_handshake_responder_if;
  import gpio_handshake_pkg::*;

  logic       enable;
  logic [7:0] checkbits_hi;
  logic [7:0] checkbits_lo;
  logic       checkbits_lo_oe;
  logic [2:0] step_idx;
  logic       busy;
  logic       pass;
  logic       fail;

  modport master (
    output enable, checkbits_hi,
    input  checkbits_lo, checkbits_lo_oe, step_idx, busy, pass, fail
  );

  modport slave (
    input  enable, checkbits_hi,
    output checkbits_lo, checkbits_lo_oe, step_idx, busy, pass, fail
  );

endinterface

// File: rtl/gpio_handshake_responder_sync2.sv
// Plain two-flop synchronizer, one independent chain per bit, used to
// bring the asynchronous pad inputs into the clock domain.
module gpio_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_handshake_responder.sv
// Off-chip partner for the management GPIO checkbit handshake: watches
// the upper byte, answers from the step table and reports pass/fail.
module gpio_handshake_responder
  import gpio_handshake_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SETTLE_CYCLES  = 1000
) (
  input logic                        clock_i,
  input logic                        reset_i,
  gpio_handshake_responder_if.slave  hs
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DW = $clog2(SETTLE_CYCLES + 1);

  state_e         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic [7:0]     lo_q, lo_d;
  logic           oe_q, oe_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [DW-1:0]  dly_q, dly_d;
  logic           en_q;
  logic [7:0]     hi_s;
  logic [7:0]     hi_prev_q;
  logic           match;
  logic           timeout;

  gpio_sync2 #(.WIDTH(8)) u_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (hs.checkbits_hi),
    .q_o     (hi_s)
  );

  // Two consecutive equal samples filter out skewed or glitching pad edges.
  assign match   = (hi_s == EXP_HI[step_q]) && (hi_prev_q == EXP_HI[step_q]);
  assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      lo_q      <= '0;
      oe_q      <= 1'b0;
      timer_q   <= '0;
      dly_q     <= '0;
      en_q      <= 1'b0;
      hi_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      lo_q      <= lo_d;
      oe_q      <= oe_d;
      timer_q   <= timer_d;
      dly_q     <= dly_d;
      en_q      <= hs.enable;
      hi_prev_q <= hi_s;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    lo_d    = lo_q;
    oe_d    = oe_q;
    timer_d = timer_q;
    dly_d   = dly_q;
    if (timer_q != TW'(TIMEOUT_CYCLES)) timer_d = timer_q + 1'b1;

    if (!hs.enable) begin
      state_d = ST_IDLE;
      step_d  = '0;
      lo_d    = '0;
      oe_d    = 1'b0;
      timer_d = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          step_d  = '0;
          lo_d    = '0;
          oe_d    = 1'b0;
          timer_d = '0;
          dly_d   = '0;
          if (!en_q) state_d = ST_WAIT_MATCH;
        end
        // A match beats a coincident timeout.
        ST_WAIT_MATCH: begin
          if (match) begin
            if (step_q == LAST_STEP) begin
              state_d = ST_PASS;
            end else if (DLY_EN[step_q]) begin
              state_d = ST_DELAY;
              dly_d   = '0;
            end else begin
              state_d = ST_DRIVE;
            end
          end else if (timeout) begin
            state_d = ST_FAIL;
          end
        end
        ST_DELAY: begin
          if (dly_q == DW'(SETTLE_CYCLES - 1)) begin
            state_d = ST_DRIVE;
          end else begin
            dly_d = dly_q + 1'b1;
            if (timeout) state_d = ST_FAIL;
          end
        end
        ST_DRIVE: begin
          lo_d    = RSP_LO[step_q];
          oe_d    = 1'b1;
          step_d  = step_q + 3'd1;
          timer_d = '0;
          state_d = ST_WAIT_MATCH;
        end
        ST_PASS, ST_FAIL: begin
          state_d = state_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign hs.checkbits_lo    = lo_q;
  assign hs.checkbits_lo_oe = oe_q;
  assign hs.step_idx        = step_q;
  assign hs.busy            = (state_q == ST_WAIT_MATCH) || (state_q == ST_DELAY) || (state_q == ST_DRIVE);
  assign hs.pass            = (state_q == ST_PASS);
  assign hs.fail            = (state_q == ST_FAIL);

endmodule

// File: tb/tb_gpio_handshake_responder.sv
// Randomized bench for the checkbit handshake responder, checked against
// a step-table model with latencies derived from the handshake timing.
module tb_gpio_handshake_responder;

  localparam int TIMEOUT = 50;
  localparam int SETTLE  = 10;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mHi [6] = '{8'hA0, 8'h0B, 8'hAB, 8'h01, 8'h02, 8'h04};
  logic [7:0] mLo [5] = '{8'hF0, 8'h0F, 8'h00, 8'h01, 8'h03};
  int         mDelay [5] = '{0, 0, 0, SETTLE, SETTLE};

  gpio_handshake_responder_if hs();

  gpio_handshake_responder #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clock_i (clock),
    .reset_i (reset),
    .hs      (hs)
  );

  always #5 clock = ~clock;

  // Two synchronizer edges, one stability compare, one drive edge.
  function automatic int expect_latency(input int step);
    return 4 + mDelay[step];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wrong(input logic [7:0] avoid, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (v == avoid) v = ~v;
      hs.checkbits_hi = v;
      tick();
    end
  endtask

  task automatic send_value(input logic [7:0] v, input logic [2:0] prevStep, output int lat);
    hs.checkbits_hi = v;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (hs.step_idx !== prevStep) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic restart();
    hs.enable = 1'b0;
    hs.checkbits_hi = 8'h00;
    tick();
    tick();
    tick();
    hs.enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    hs.enable = 1'b0;
    hs.checkbits_hi = 8'h00;
    #12;
    checks++; if (hs.checkbits_lo !== 8'h00) begin errors++; $display("FAIL reset_lo: got %h expected 00", hs.checkbits_lo); end
    checks++; if (hs.checkbits_lo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", hs.checkbits_lo_oe); end
    checks++; if (hs.step_idx !== 3'd0) begin errors++; $display("FAIL reset_step: got %0d expected 0", hs.step_idx); end
    checks++; if ({hs.busy, hs.pass, hs.fail} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {hs.busy, hs.pass, hs.fail}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int lat;
    restart();
    tick();
    checks++; if (hs.busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_rise: got %b expected 1", hs.busy); end
    for (int i = 0; i < 5; i++) begin
      drive_wrong(mHi[i], $urandom_range(0, 5));
      send_value(mHi[i], 3'(i), lat);
      checks++; if (lat != expect_latency(i)) begin errors++; $display("FAIL nominal_latency step %0d: got %0d expected %0d", i, lat, expect_latency(i)); end
      checks++; if (hs.checkbits_lo !== mLo[i]) begin errors++; $display("FAIL nominal_lo step %0d: got %h expected %h", i, hs.checkbits_lo, mLo[i]); end
      checks++; if (hs.checkbits_lo_oe !== 1'b1) begin errors++; $display("FAIL nominal_oe step %0d: got %b expected 1", i, hs.checkbits_lo_oe); end
    end
    drive_wrong(mHi[5], $urandom_range(0, 5));
    hs.checkbits_hi = mHi[5];
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (hs.pass === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL nominal_pass_latency: got %0d expected 3", lat); end
    checks++; if (hs.busy !== 1'b0) begin errors++; $display("FAIL nominal_pass_busy: got %b expected 0", hs.busy); end
    checks++; if (hs.checkbits_lo !== mLo[4]) begin errors++; $display("FAIL nominal_pass_lo: got %h expected %h", hs.checkbits_lo, mLo[4]); end
    checks++; if (hs.step_idx !== 3'd5) begin errors++; $display("FAIL nominal_pass_step: got %0d expected 5", hs.step_idx); end
  endtask

  task automatic test_timeout();
    int lat;
    int failN;
    restart();
    send_value(mHi[0], 3'd0, lat);
    checks++; if (lat != expect_latency(0)) begin errors++; $display("FAIL timeout_first_latency: got %0d expected %0d", lat, expect_latency(0)); end
    failN = -1;
    for (int n = 1; n < 120; n++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (v == mHi[1]) v = mHi[0];
      hs.checkbits_hi = v;
      tick();
      if (hs.fail === 1'b1) begin
        failN = n;
        break;
      end
    end
    checks++; if (failN != TIMEOUT) begin errors++; $display("FAIL timeout_cycles: got %0d expected %0d", failN, TIMEOUT); end
    checks++; if (hs.step_idx !== 3'd1) begin errors++; $display("FAIL timeout_step: got %0d expected 1", hs.step_idx); end
    checks++; if (hs.checkbits_lo !== mLo[0]) begin errors++; $display("FAIL timeout_lo: got %h expected %h", hs.checkbits_lo, mLo[0]); end
    checks++; if ({hs.busy, hs.checkbits_lo_oe} !== 2'b01) begin errors++; $display("FAIL timeout_busy_oe: got %b expected 01", {hs.busy, hs.checkbits_lo_oe}); end
  endtask

  task automatic test_glitch();
    int lat;
    restart();
    hs.checkbits_hi = mHi[0];
    tick();
    hs.checkbits_hi = 8'h00;
    for (int n = 0; n < 10; n++) tick();
    checks++; if (hs.checkbits_lo_oe !== 1'b0) begin errors++; $display("FAIL glitch_oe: got %b expected 0", hs.checkbits_lo_oe); end
    checks++; if (hs.step_idx !== 3'd0) begin errors++; $display("FAIL glitch_step: got %0d expected 0", hs.step_idx); end
    hs.checkbits_hi = mHi[0];
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (n == 2) hs.checkbits_hi = 8'h00;
      if (hs.step_idx !== 3'd0) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL glitch_pulse3_latency: got %0d expected 4", lat); end
    checks++; if (hs.checkbits_lo !== mLo[0]) begin errors++; $display("FAIL glitch_pulse3_lo: got %h expected %h", hs.checkbits_lo, mLo[0]); end
  endtask

  task automatic test_out_of_order();
    int failN;
    restart();
    failN = -1;
    for (int n = 0; n < 120; n++) begin
      hs.checkbits_hi = mHi[$urandom_range(1, 5)];
      tick();
      if (n == 45) begin
        checks++; if ({hs.step_idx, hs.fail, hs.checkbits_lo_oe} !== 5'b00000) begin errors++; $display("FAIL ooo_ignored: got step %0d fail %b oe %b expected 0 0 0", hs.step_idx, hs.fail, hs.checkbits_lo_oe); end
      end
      if (hs.fail === 1'b1) begin
        failN = n;
        break;
      end
    end
    checks++; if (failN != TIMEOUT) begin errors++; $display("FAIL ooo_timeout: got %0d expected %0d", failN, TIMEOUT); end
  endtask

  task automatic test_abort();
    int lat;
    restart();
    for (int i = 0; i < 3; i++) send_value(mHi[i], 3'(i), lat);
    checks++; if (hs.step_idx !== 3'd3) begin errors++; $display("FAIL abort_reach_step3: got %0d expected 3", hs.step_idx); end
    hs.checkbits_hi = mHi[3];
    for (int n = 0; n < 8; n++) tick();
    hs.enable = 1'b0;
    tick();
    checks++; if ({hs.checkbits_lo_oe, hs.busy, hs.pass, hs.fail} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b expected 0000", {hs.checkbits_lo_oe, hs.busy, hs.pass, hs.fail}); end
    checks++; if ({hs.step_idx, hs.checkbits_lo} !== 11'd0) begin errors++; $display("FAIL abort_step_lo: got %0d/%h expected 0/00", hs.step_idx, hs.checkbits_lo); end
    hs.checkbits_hi = 8'h00;
    tick();
    tick();
    tick();
    hs.enable = 1'b1;
    tick();
    checks++; if ({hs.busy, hs.step_idx} !== 4'b1000) begin errors++; $display("FAIL abort_restart: got busy %b step %0d expected 1 0", hs.busy, hs.step_idx); end
    send_value(mHi[0], 3'd0, lat);
    checks++; if (lat != expect_latency(0) || hs.checkbits_lo !== mLo[0]) begin errors++; $display("FAIL abort_rerun: got lat %0d lo %h expected %0d %h", lat, hs.checkbits_lo, expect_latency(0), mLo[0]); end
  endtask

  task automatic test_async_reset();
    int lat;
    restart();
    for (int i = 0; i < 3; i++) send_value(mHi[i], 3'(i), lat);
    hs.checkbits_hi = mHi[3];
    for (int n = 0; n < 6; n++) tick();
    #3;
    reset = 1'b1;
    #1;
    checks++; if ({hs.checkbits_lo, hs.checkbits_lo_oe} !== 9'd0) begin errors++; $display("FAIL async_reset_lo_oe: got %h/%b expected 00/0", hs.checkbits_lo, hs.checkbits_lo_oe); end
    checks++; if ({hs.step_idx, hs.busy, hs.pass, hs.fail} !== 6'd0) begin errors++; $display("FAIL async_reset_status: got %b expected 000000", {hs.step_idx, hs.busy, hs.pass, hs.fail}); end
    #1;
    reset = 1'b0;
    hs.enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_out_of_order();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_handshake_responder.md
# gpio_handshake_responder

Synthesizable off-chip-side partner for the management GPIO checkbit handshake. It watches the upper checkbit byte (mprj_io[31:24]) that the management firmware drives and answers on the lower byte (mprj_io[23:16]) from a fixed step table. It reports pass/fail, so the same handshake can run on an FPGA harness or bring-up board instead of a simulation-only transactor. It sits directly on the pad side of the user GPIO bank.

## Interface
Parameters:
- TIMEOUT_CYCLES, 25000: maximum cycles spent waiting in any single step before failing.
- SETTLE_CYCLES, 1000: delay inserted before the responses of delayed steps.

Ports:
- clock  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level. Rising edge starts a run. Low aborts the run and returns to IDLE.
- checkbits_hi  in  8  pad inputs mprj_io[31:24]; asynchronous to clock.
- checkbits_lo  out  8  response value for mprj_io[23:16].
- checkbits_lo_oe  out  1  pad output enable for checkbits_lo; the pads are tri-stated when low.
- step_idx  out  3  current step number, 0..5.
- busy  out  1  high while a run is in progress.
- pass  out  1  sticky high after step 5 matches; stays high until enable goes low or reset.
- fail  out  1  sticky high on timeout; stays high until enable goes low or reset.

## Operation
Step table, written as (expected hi, response lo, delay):
- 0: (A0, F0, 0)
- 1: (0B, 0F, 0)
- 2: (AB, 00, 0)
- 3: (01, 01, SETTLE)
- 4: (02, 03, SETTLE)
- 5: (04, none). A match here is the terminal pass.

Input conditioning:
- checkbits_hi passes through a 2-flop synchronizer, giving hi_s.
- A match requires hi_s to equal the expected value on two consecutive cycles. This rejects multi-bit skew and glitches.

FSM states: IDLE, WAIT_MATCH, DELAY, DRIVE, PASS, FAIL.
- IDLE: all outputs are at their reset values. An enable rising edge goes to WAIT_MATCH with step 0 and the timer cleared.
- WAIT_MATCH: on match, go to DELAY if the step's delay is nonzero, else to DRIVE. Step 5 match goes to PASS. Timer reaching TIMEOUT_CYCLES-1 goes to FAIL.
- DELAY: counts SETTLE_CYCLES, then goes to DRIVE. The timeout keeps counting here.
- DRIVE (1 cycle): load checkbits_lo with the step's response and set checkbits_lo_oe=1. Increment step_idx, clear the timer, go to WAIT_MATCH.
- PASS / FAIL: set the sticky flag, clear busy, hold checkbits_lo and oe. Leave only when enable goes low, then go to IDLE.

Outputs and counters:
- checkbits_lo_oe stays 0 until the first DRIVE and remains 1 until IDLE.
- Reset values: checkbits_lo=00, checkbits_lo_oe=0, step_idx=0, busy=0, pass=0, fail=0, FSM=IDLE, counters=0.
- The timer is a free-running up-counter that saturates. Its width is clog2(TIMEOUT_CYCLES+1). The delay counter width is clog2(SETTLE_CYCLES+1).

Boundary conditions:
- Match and timeout in the same cycle: match wins.
- A non-expected hi value, including a later-step value, is ignored. Wrong values alone never cause failure.
- enable low in any state: go to IDLE on the next edge, with oe=0 and the flags cleared.
- reset mid-run: all outputs go to their reset values immediately, since reset is asynchronous.

## Timing
- Latency from checkbits_hi settling, sampled at edge k, to match detection is 3 edges: 2 synchronizer edges plus the stability compare.
- With zero delay, checkbits_lo and oe update at edge k+4.
- With SETTLE delay, checkbits_lo updates at edge k+4+SETTLE_CYCLES.
- busy rises 1 cycle after the enable rising edge is sampled.
- pass and fail assert 1 cycle after the terminal event.

## Structure
- Package gpio_handshake_pkg holds:
  - the FSM state encoding;
  - the step-table constants EXP_HI[0:5], RSP_LO[0:4] and DLY_EN[0:4];
  - N_STEPS=6.
- Sub-module gpio_sync2: a per-bit 2-flop synchronizer with asynchronous active-high reset to 0, instantiated 8 wide.
- The top module contains the FSM, the two counters and the output registers.

## Test plan
- Nominal run (SETTLE_CYCLES=10): a model drives A0, 0B, AB, 01, 02, 04, each after seeing the previous response. Required: checkbits_lo goes F0, 0F, 00, 01, 03; pass=1 after 04; 01 and 03 appear at least 10 cycles after their matches.
- Timeout (TIMEOUT_CYCLES=50): hold hi=A0, then never drive 0B. Required: fail=1 50 cycles after the F0 drive, step_idx=1, checkbits_lo holds F0.
- Glitch rejection: a 1-cycle pulse of A0 on hi. Required: no response and oe stays 0. A 3-cycle A0 pulse: F0 driven at the 4th edge.
- Out-of-order values: drive AB while at step 0. Required: ignored, step_idx stays 0, no fail before the timeout.
- Abort: drop enable at step 3. Required: next cycle IDLE, oe=0, busy=0, pass=0. A new enable edge restarts at step 0.
- Asynchronous reset mid-DELAY: assert reset between edges. Required: all outputs are at their reset values before the next edge.
